// File: rtl/lcd_string_refresher.sv
// lcd_string_refresher: HD44780 power-up init, then endless refresh of a 32-slot string buffer
// onto a 2x16 LCD over the 8-bit parallel bus.
`default_nettype none

module lcd_string_refresher #(
  parameter int unsigned CLK_DIV      = 16,
  parameter int unsigned GAP_CYCLES   = 2000,
  parameter int unsigned CLEAR_CYCLES = 80000,
  parameter int unsigned PWRUP_CYCLES = 1000000
) (
  input  logic       clock,
  input  logic       resetn,
  output logic [4:0] index,
  input  logic [7:0] char_in,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic       init_done,
  output logic       frame_done
);

  localparam logic [2:0] S_PWRUP = 3'd0;
  localparam logic [2:0] S_NEXT  = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_SETUP = 3'd3;
  localparam logic [2:0] S_EN_HI = 3'd4;
  localparam logic [2:0] S_HOLD  = 3'd5;
  localparam logic [2:0] S_GAP   = 3'd6;

  // Steps 0..3 are init commands; 4..37 are the repeating frame.
  localparam logic [5:0] STEP_CLEAR  = 6'd2;
  localparam logic [5:0] STEP_INIT_Z = 6'd3;
  localparam logic [5:0] STEP_FRAME0 = 6'd4;
  localparam logic [5:0] STEP_ROW2   = 6'd21;
  localparam logic [5:0] STEP_LAST   = 6'd37;

  logic [2:0]  state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic [5:0]  step_q, step_d;
  logic [4:0]  index_q, index_d;
  logic [7:0]  data_q, data_d;
  logic        rs_q, rs_d;
  logic        en_q, en_d;
  logic        init_done_q, init_done_d;
  logic        frame_done_q, frame_done_d;

  logic [23:0] cnt_last;
  logic        cnt_done;
  logic        is_char;
  logic [7:0]  cmd_byte;
  logic [4:0]  slot;
  logic [5:0]  off5, off6;
  logic [7:0]  char_clean;
  logic        gap_end;

  always_comb begin
    off5     = step_q - 6'd5;
    off6     = step_q - 6'd6;
    is_char  = 1'b0;
    cmd_byte = 8'h00;
    slot     = 5'd0;
    case (step_q)
      6'd0:      cmd_byte = 8'h38;
      6'd1:      cmd_byte = 8'h0C;
      STEP_CLEAR: cmd_byte = 8'h01;
      STEP_INIT_Z: cmd_byte = 8'h06;
      STEP_FRAME0: cmd_byte = 8'h80;
      STEP_ROW2: cmd_byte = 8'hC0;
      default: begin
        is_char = 1'b1;
        slot    = (step_q < STEP_ROW2) ? off5[4:0] : off6[4:0];
      end
    endcase
  end

  always_comb begin
    cnt_last = 24'd0;
    case (state_q)
      S_PWRUP:                  cnt_last = 24'(PWRUP_CYCLES - 1);
      S_FETCH:                  cnt_last = 24'd1;
      S_SETUP, S_EN_HI, S_HOLD: cnt_last = 24'(CLK_DIV - 1);
      S_GAP: cnt_last = (step_q == STEP_CLEAR) ? 24'(CLEAR_CYCLES - 1) : 24'(GAP_CYCLES - 1);
      default:                  cnt_last = 24'd0;
    endcase
    cnt_done   = (cnt_q == cnt_last);
    gap_end    = (state_q == S_GAP) && cnt_done;
    // Control codes and DEL would render as garbage glyphs; show a blank instead.
    char_clean = ((char_in < 8'h20) || (char_in == 8'h7F)) ? 8'h20 : char_in;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q      <= S_PWRUP;
      cnt_q        <= 24'd0;
      step_q       <= 6'd0;
      index_q      <= 5'd0;
      data_q       <= 8'h00;
      rs_q         <= 1'b0;
      en_q         <= 1'b0;
      init_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      step_q       <= step_d;
      index_q      <= index_d;
      data_q       <= data_d;
      rs_q         <= rs_d;
      en_q         <= en_d;
      init_done_q  <= init_done_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 24'd1;
    step_d  = step_q;
    case (state_q)
      S_PWRUP: if (cnt_done) begin state_d = S_NEXT;  cnt_d = 24'd0; end
      S_NEXT: begin
        state_d = is_char ? S_FETCH : S_SETUP;
        cnt_d   = 24'd0;
      end
      S_FETCH: if (cnt_done) begin state_d = S_SETUP; cnt_d = 24'd0; end
      S_SETUP: if (cnt_done) begin state_d = S_EN_HI; cnt_d = 24'd0; end
      S_EN_HI: if (cnt_done) begin state_d = S_HOLD;  cnt_d = 24'd0; end
      S_HOLD:  if (cnt_done) begin state_d = S_GAP;   cnt_d = 24'd0; end
      S_GAP: if (cnt_done) begin
        state_d = S_NEXT;
        cnt_d   = 24'd0;
        step_d  = (step_q == STEP_LAST) ? STEP_FRAME0 : step_q + 6'd1;
      end
      default: begin state_d = S_PWRUP; cnt_d = 24'd0; end
    endcase
  end

  always_comb begin
    index_d = index_q;
    data_d  = data_q;
    rs_d    = rs_q;
    if (state_q == S_NEXT) begin
      if (is_char) begin
        index_d = slot;
      end else begin
        data_d = cmd_byte;
        rs_d   = 1'b0;
      end
    end
    if ((state_q == S_FETCH) && cnt_done) begin
      data_d = char_clean;
      rs_d   = 1'b1;
    end
    if (gap_end && (step_q == STEP_LAST)) index_d = 5'd0;
    en_d         = (state_d == S_EN_HI);
    init_done_d  = init_done_q | (gap_end && (step_q == STEP_INIT_Z));
    frame_done_d = gap_end && (step_q == STEP_LAST);
  end

  assign index      = index_q;
  assign lcd_data   = data_q;
  assign lcd_rs     = rs_q;
  assign lcd_rw     = 1'b0;
  assign lcd_en     = en_q;
  assign init_done  = init_done_q;
  assign frame_done = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_lcd_string_refresher.sv
// Scoreboard bench for lcd_string_refresher: expected LCD writes are queued by the stimulus
// and checked by a monitor at every lcd_en falling edge.
`default_nettype none

module tb_lcd_string_refresher;

  localparam int unsigned CLK_DIV = 2;
  localparam int unsigned GAP     = 4;
  localparam int unsigned CLEAR   = 8;
  localparam int unsigned PWRUP   = 10;
  // 2 commands of 11 cycles plus 32 chars of 13 cycles.
  localparam int FRAME_PERIOD = 438;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [4:0] index;
  logic [7:0] char_in = 8'h00;
  logic [7:0] lcd_data;
  logic       lcd_rs, lcd_rw, lcd_en, init_done, frame_done;

  lcd_string_refresher #(
    .CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP), .CLEAR_CYCLES(CLEAR), .PWRUP_CYCLES(PWRUP)
  ) dut (
    .clock(clock), .resetn(resetn), .index(index), .char_in(char_in),
    .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en),
    .init_done(init_done), .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  logic [7:0] mem [32];
  always @(posedge clock) char_in <= mem[index];

  int cyc = 0;
  always @(posedge clock) cyc <= resetn ? cyc + 1 : 0;

  typedef struct {
    logic       rs;
    logic [7:0] d;
    logic [4:0] idx;
    int         gap;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;
  int  n_writes = 0;
  int  fd_count = 0;
  int  fd_last = 0;
  bit  prev_en = 1'b0;
  bit  prev_fd = 1'b0;
  int  rise_cyc = 0;
  int  last_fall = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic rs, input logic [7:0] d, input logic [4:0] idx, input int gap);
    wr_t e;
    e.rs = rs; e.d = d; e.idx = idx; e.gap = gap;
    exp_q.push_back(e);
  endtask

  // Fall-to-rise intervals: hold 2 + gap + NEXT 1 + setup 2 (+2 fetch for chars).
  task automatic push_init();
    push(1'b0, 8'h38, 5'd0, 13);
    push(1'b0, 8'h0C, 5'd0, 9);
    push(1'b0, 8'h01, 5'd0, 9);
    push(1'b0, 8'h06, 5'd0, 13);
  endtask

  task automatic push_frame(input logic [127:0] r1, input logic [127:0] r2);
    push(1'b0, 8'h80, 5'd0, 9);
    for (int i = 0; i < 16; i++) push(1'b1, r1[127-8*i -: 8], 5'(i), 11);
    push(1'b0, 8'hC0, 5'd15, 9);
    for (int i = 0; i < 16; i++) push(1'b1, r2[127-8*i -: 8], 5'(16 + i), 11);
  endtask

  task automatic load_rows(input logic [127:0] r1, input logic [127:0] r2);
    for (int i = 0; i < 16; i++) begin
      mem[i]      = r1[127-8*i -: 8];
      mem[16 + i] = r2[127-8*i -: 8];
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_index"}, index, 0);
    chk({tag, "_data"}, lcd_data, 8'h00);
    chk({tag, "_ctrl"}, {lcd_rs, lcd_rw, lcd_en, init_done, frame_done}, 5'b00000);
  endtask

  task automatic wait_frame(input string tag);
    int start;
    start = fd_count;
    for (int i = 0; i < 2000 && fd_count == start; i++) @(negedge clock);
    if (fd_count == start) chk({tag, "_timeout"}, 0, 1);
  endtask

  always @(negedge clock) begin
    if (resetn) begin
      if (lcd_en && !prev_en) begin
        rise_cyc = cyc;
        if (exp_q.size() > 0) chk("en_rise_interval", cyc - last_fall, exp_q[0].gap);
      end
      if (!lcd_en && prev_en) begin
        wr_t e;
        chk("en_width", cyc - rise_cyc, CLK_DIV);
        if (exp_q.size() == 0) begin
          chk("unexpected_write", lcd_data, 9'h1FF);
        end else begin
          e = exp_q.pop_front();
          chk("write_rs_rw", {lcd_rs, lcd_rw}, {e.rs, 1'b0});
          chk("write_data", lcd_data, e.d);
          chk("write_index", index, e.idx);
        end
        last_fall = cyc;
        n_writes++;
      end
      if (frame_done) begin
        if (prev_fd) chk("frame_done_width", 2, 1);
        if (fd_count > 0) chk("frame_period", cyc - fd_last, FRAME_PERIOD);
        fd_last = cyc;
        fd_count++;
      end
      prev_en = lcd_en;
      prev_fd = frame_done;
    end
  end

  logic [127:0] r1a, r2a, r1b_exp, r2b_exp;

  initial begin
    int i;
    r1a     = "HELLO WORLD 2024";
    r2a     = "SPINNAKER DVS OK";
    r1b_exp = "HELQO WORLD 2024";
    r2b_exp = {"SPIN", 8'h20, 8'h7E, "KER DVS O", 8'h20};
    load_rows(r1a, r2a);
    push_init();
    push_frame(r1a, r2a);
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("reset");
    resetn = 1'b1;

    for (i = 0; i < 500 && !init_done; i++) begin
      @(negedge clock);
      if (!init_done) chk("init_done_early", init_done, (n_writes < 4) ? 0 : init_done);
    end
    chk("init_done_rise", init_done, 1);
    chk("init_writes", n_writes, 4);

    wait_frame("frame1");
    chk("frame1_drained", exp_q.size(), 0);
    mem[3]  = "Q";
    mem[5]  = 8'h0A;
    mem[20] = 8'h7F;
    mem[21] = 8'h7E;
    mem[31] = 8'h1F;
    push_frame(r1b_exp, r2b_exp);
    wait_frame("frame2");
    chk("frame2_drained", exp_q.size(), 0);
    chk("frame_count", fd_count, 2);

    // Hit a row-2 char while lcd_en is high, then reset for one edge.
    push_frame(r1b_exp, r2b_exp);
    for (i = 0; i < 2000 && !(lcd_en && lcd_rs && index == 5'd20); i++) @(negedge clock);
    chk("reach_row2_en_hi", {lcd_en, lcd_rs, index}, {2'b11, 5'd20});
    resetn = 1'b0;
    exp_q.delete();
    @(posedge clock);
    #1;
    check_reset_outputs("midreset");
    prev_en = 1'b0;
    prev_fd = 1'b0;
    last_fall = 0;
    n_writes = 0;
    fd_count = 0;
    push_init();
    push_frame(r1b_exp, r2b_exp);
    resetn = 1'b1;
    wait_frame("restart");
    chk("restart_writes", n_writes, 38);
    chk("restart_init_done", init_done, 1);
    chk("restart_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
